// File: rtl/vec_issue_queue_pkg.sv
// Shared constants for the vector issue path: datapath width, queue depth, vector opcodes.
// Also provides the legal-opcode helper used by the issue decoder and the core hazard logic.
// Pure declarations; no state.
package vec_issue_queue_pkg;

  localparam int VIQ_WORD_WIDTH = 32;
  localparam int VIQ_DEPTH      = 4;

  localparam logic [6:0] OPC_OPV     = 7'h57;
  localparam logic [6:0] OPC_LOADFP  = 7'h07;
  localparam logic [6:0] OPC_STOREFP = 7'h27;

  // True for the major opcodes that the vector coprocessor executes
  function automatic logic is_vec_opcode(input logic [6:0] opc);
    return (opc == OPC_OPV) || (opc == OPC_LOADFP) || (opc == OPC_STOREFP);
  endfunction

endpackage

// File: rtl/vec_issue_decode.sv
// Purpose: combinational legal-opcode check for vector instructions.
// Latency: zero cycles (pure combinational).
// Backpressure: none; evaluates whatever opcode is presented.
module vec_issue_decode
  import vec_issue_queue_pkg::*;
(
  input  logic [6:0] opcode,
  output logic       legal
);

  // Only OP-V and the FP load/store encodings (vector memory ops) are accepted
  always_comb begin
    legal = is_vec_opcode(opcode);
  end

endmodule

// File: rtl/vec_issue_queue.sv
// Purpose: FIFO of vector instructions plus scalar-operand snapshots between core and coprocessor.
// Latency: push at cycle N is visible at out_* in cycle N+1; no bypass when empty.
// Backpressure: in_ready = !full from registered count only; out_ready never reaches in_ready.
module vec_issue_queue
  import vec_issue_queue_pkg::*;
#(
  parameter int DEPTH      = VIQ_DEPTH,
  parameter int PTR_BITS   = $clog2(DEPTH),
  parameter int WORD_WIDTH = VIQ_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WORD_WIDTH-1:0] in_instr,
  input  logic [WORD_WIDTH-1:0] in_xrs1,
  input  logic [WORD_WIDTH-1:0] in_xrs2,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WORD_WIDTH-1:0] out_instr,
  output logic [WORD_WIDTH-1:0] out_xrs1,
  output logic [WORD_WIDTH-1:0] out_xrs2,
  output logic [PTR_BITS:0]     count,
  output logic                  empty,
  output logic                  illegal
);

  localparam logic [PTR_BITS:0]   FULL_CNT = (PTR_BITS + 1)'(DEPTH);
  localparam logic [PTR_BITS-1:0] PTR_ONE  = PTR_BITS'(1);
  localparam logic [PTR_BITS:0]   CNT_ONE  = (PTR_BITS + 1)'(1);

  logic [PTR_BITS-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_BITS-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PTR_BITS:0]     count_q, count_d;
  logic                  illegal_q, illegal_d;
  logic [WORD_WIDTH-1:0] instr_q [DEPTH];
  logic [WORD_WIDTH-1:0] instr_d [DEPTH];
  logic [WORD_WIDTH-1:0] xrs1_q  [DEPTH];
  logic [WORD_WIDTH-1:0] xrs1_d  [DEPTH];
  logic [WORD_WIDTH-1:0] xrs2_q  [DEPTH];
  logic [WORD_WIDTH-1:0] xrs2_d  [DEPTH];

  logic legal;
  logic in_fire;
  logic push;
  logic pop;

  vec_issue_decode u_decode (
    .opcode (in_instr[6:0]),
    .legal  (legal)
  );

  // Status and head data are taken straight from registered state
  always_comb begin
    in_ready  = (count_q != FULL_CNT);
    empty     = (count_q == '0);
    out_valid = !empty;
    count     = count_q;
    illegal   = illegal_q;
    out_instr = instr_q[rd_ptr_q];
    out_xrs1  = xrs1_q[rd_ptr_q];
    out_xrs2  = xrs2_q[rd_ptr_q];
  end

  // Next-state: handshakes, pointer/count update, entry writes; flush overrides everything
  always_comb begin
    in_fire   = in_valid && in_ready;
    push      = in_fire && legal;
    pop       = out_valid && out_ready;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    illegal_d = in_fire && !legal && !flush;
    instr_d   = instr_q;
    xrs1_d    = xrs1_q;
    xrs2_d    = xrs2_q;

    if (push) begin
      instr_d[wr_ptr_q] = in_instr;
      xrs1_d[wr_ptr_q]  = in_xrs1;
      xrs2_d[wr_ptr_q]  = in_xrs2;
      wr_ptr_d          = wr_ptr_q + PTR_ONE;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    // Entries written by a dropped push are harmless: pointers and count restart at zero
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end
  end

  // State registers; reset also clears entries so out_* read zero after reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      illegal_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        instr_q[i] <= '0;
        xrs1_q[i]  <= '0;
        xrs2_q[i]  <= '0;
      end
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      illegal_q <= illegal_d;
      instr_q   <= instr_d;
      xrs1_q    <= xrs1_d;
      xrs2_q    <= xrs2_d;
    end
  end

endmodule

// File: tb/tb_vec_issue_queue.sv
// Directed bench for vec_issue_queue: table of one-cycle vectors plus hand-written sequences.
// Each vector is driven for one clock; outputs are compared 1 time unit after the edge.
// Streaming, pointer wrap and asynchronous reset are exercised by dedicated sequences.
module tb_vec_issue_queue;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_xrs1;
  logic [31:0] in_xrs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_xrs1;
  logic [31:0] out_xrs2;
  logic [2:0]  count;
  logic        empty;
  logic        illegal;

  int checks;
  int failures;

  vec_issue_queue dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_instr  (in_instr),
    .in_xrs1   (in_xrs1),
    .in_xrs2   (in_xrs2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_instr (out_instr),
    .out_xrs1  (out_xrs1),
    .out_xrs2  (out_xrs2),
    .count     (count),
    .empty     (empty),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [31:0] instr;
    logic [31:0] x1;
    logic [31:0] x2;
    logic        ordy;
    logic        fl;
    logic        e_ov;
    logic [31:0] e_oi;
    logic [31:0] e_x1;
    logic [31:0] e_x2;
    logic [2:0]  e_cnt;
    logic        e_ir;
    logic        e_ill;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic vld, input logic [31:0] instr, input logic [31:0] x1,
                              input logic [31:0] x2, input logic ordy, input logic fl,
                              input logic e_ov, input logic [31:0] e_oi, input logic [31:0] e_x1,
                              input logic [31:0] e_x2, input logic [2:0] e_cnt, input logic e_ir,
                              input logic e_ill);
    vec_t v;
    v.vld = vld; v.instr = instr; v.x1 = x1; v.x2 = x2; v.ordy = ordy; v.fl = fl;
    v.e_ov = e_ov; v.e_oi = e_oi; v.e_x1 = e_x1; v.e_x2 = e_x2;
    v.e_cnt = e_cnt; v.e_ir = e_ir; v.e_ill = e_ill;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic vld, input logic [31:0] instr, input logic [31:0] x1,
                       input logic [31:0] x2, input logic ordy, input logic fl);
    in_valid  = vld;
    in_instr  = instr;
    in_xrs1   = x1;
    in_xrs2   = x2;
    out_ready = ordy;
    flush     = fl;
  endtask

  localparam logic [31:0] I0 = 32'h0220_8057;
  localparam logic [31:0] A1 = 32'h0000_1057;
  localparam logic [31:0] A2 = 32'h0000_2007;
  localparam logic [31:0] A3 = 32'h0000_3027;
  localparam logic [31:0] A4 = 32'h0000_4057;
  localparam logic [31:0] A5 = 32'h0000_5057;
  localparam logic [31:0] BAD = 32'h0000_0033;
  localparam logic [31:0] B1 = 32'h0001_1057;
  localparam logic [31:0] B2 = 32'h0001_2007;
  localparam logic [31:0] B3 = 32'h0001_3027;
  localparam logic [31:0] B4 = 32'h0001_4057;
  localparam logic [31:0] C1 = 32'h0002_1027;

  initial begin
    checks   = 0;
    failures = 0;

    //            vld  instr  x1  x2  ordy fl   ov  oi  ox1 ox2 cnt ir ill
    // single push, hold three cycles with out_ready low, then pop
    vecs.push_back(mk(1, I0,  5,  9,  0, 0,  1, I0,  5,  9, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  0, 0,  1, I0,  5,  9, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  0, 0,  1, I0,  5,  9, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  0, 0,  1, I0,  5,  9, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  1, 0,  0, 0,   0,  0, 0, 1, 0));
    // fill to full; a fifth push is refused, also while a pop happens
    vecs.push_back(mk(1, A1, 11, 21,  0, 0,  1, A1, 11, 21, 1, 1, 0));
    vecs.push_back(mk(1, A2, 12, 22,  0, 0,  1, A1, 11, 21, 2, 1, 0));
    vecs.push_back(mk(1, A3, 13, 23,  0, 0,  1, A1, 11, 21, 3, 1, 0));
    vecs.push_back(mk(1, A4, 14, 24,  0, 0,  1, A1, 11, 21, 4, 0, 0));
    vecs.push_back(mk(1, A5, 15, 25,  0, 0,  1, A1, 11, 21, 4, 0, 0));
    vecs.push_back(mk(1, A5, 15, 25,  1, 0,  1, A2, 12, 22, 3, 1, 0));
    // drain in push order
    vecs.push_back(mk(0, 0,   0,  0,  1, 0,  1, A3, 13, 23, 2, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  1, 0,  1, A4, 14, 24, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  1, 0,  0, 0,   0,  0, 0, 1, 0));
    // illegal opcode: consumed, one-cycle pulse, nothing queued
    vecs.push_back(mk(1, BAD, 7,  8,  0, 0,  0, 0,   0,  0, 0, 1, 1));
    vecs.push_back(mk(0, 0,   0,  0,  0, 0,  0, 0,   0,  0, 0, 1, 0));
    // three entries, then flush with concurrent push and pop
    vecs.push_back(mk(1, B1, 31, 41,  0, 0,  1, B1, 31, 41, 1, 1, 0));
    vecs.push_back(mk(1, B2, 32, 42,  0, 0,  1, B1, 31, 41, 2, 1, 0));
    vecs.push_back(mk(1, B3, 33, 43,  0, 0,  1, B1, 31, 41, 3, 1, 0));
    vecs.push_back(mk(1, B4, 34, 44,  1, 1,  0, 0,   0,  0, 0, 1, 0));
    // flush suppresses a concurrent illegal pulse
    vecs.push_back(mk(1, BAD, 0,  0,  0, 1,  0, 0,   0,  0, 0, 1, 0));
    // after flush the queue restarts cleanly
    vecs.push_back(mk(1, C1, 51, 61,  0, 0,  1, C1, 51, 61, 1, 1, 0));
    vecs.push_back(mk(0, 0,   0,  0,  1, 0,  0, 0,   0,  0, 0, 1, 0));

    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0);
    #12;
    rst = 1'b0;
    #1;
    chk("reset_empty",     {31'd0, empty},     32'd1);
    chk("reset_count",     {29'd0, count},     32'd0);
    chk("reset_in_ready",  {31'd0, in_ready},  32'd1);
    chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
    chk("reset_illegal",   {31'd0, illegal},   32'd0);
    chk("reset_out_instr", out_instr,          32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].vld, vecs[i].instr, vecs[i].x1, vecs[i].x2, vecs[i].ordy, vecs[i].fl);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, vecs[i].e_ov});
      chk($sformatf("v%0d_count", i),     {29'd0, count},     {29'd0, vecs[i].e_cnt});
      chk($sformatf("v%0d_empty", i),     {31'd0, empty},     {31'd0, vecs[i].e_cnt == 3'd0});
      chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready},  {31'd0, vecs[i].e_ir});
      chk($sformatf("v%0d_illegal", i),   {31'd0, illegal},   {31'd0, vecs[i].e_ill});
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_out_instr", i), out_instr, vecs[i].e_oi);
        chk($sformatf("v%0d_out_xrs1", i),  out_xrs1,  vecs[i].e_x1);
        chk($sformatf("v%0d_out_xrs2", i),  out_xrs2,  vecs[i].e_x2);
      end
    end

    // Streaming: push and pop every cycle; head is always the item pushed last cycle
    for (int i = 0; i < 20; i++) begin
      drive(1, 32'h0000_0057 | (32'(i) << 12), 32'd100 + 32'(i), 32'd200 + 32'(i), 1, 0);
      @(posedge clk);
      #1;
      chk($sformatf("stream%0d_count", i),     {29'd0, count},     32'd1);
      chk($sformatf("stream%0d_out_valid", i), {31'd0, out_valid}, 32'd1);
      chk($sformatf("stream%0d_out_xrs1", i),  out_xrs1,           32'd100 + 32'(i));
      chk($sformatf("stream%0d_out_instr", i), out_instr,          32'h0000_0057 | (32'(i) << 12));
    end
    drive(0, 0, 0, 0, 1, 0);
    @(posedge clk);
    #1;
    chk("stream_drain_count", {29'd0, count}, 32'd0);

    // Asynchronous reset mid-stream: state clears before the next clock edge
    drive(1, A1, 1, 2, 0, 0);
    @(posedge clk);
    #1;
    drive(1, A2, 3, 4, 0, 0);
    @(posedge clk);
    #1;
    chk("pre_rst_count", {29'd0, count}, 32'd2);
    drive(0, 0, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    #1;
    chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_count",     {29'd0, count},     32'd0);
    chk("async_rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("async_rst_out_instr", out_instr,          32'd0);
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_rst_empty", {31'd0, empty}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
